// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the BNN inference sequencer.
package bnn_pkg;

    localparam int unsigned DefImgBytes = 8;
    localparam int unsigned DefNClasses = 4;

    typedef enum logic [1:0] {
        S_RECV,
        S_COMP,
        S_SEND_CLS,
        S_SEND_SCORE
    } state_e;

    // Width of a per-class XNOR-popcount total (0 .. img_bytes*8 inclusive).
    function automatic int unsigned acc_width(input int unsigned img_bytes);
        return $clog2(img_bytes * 8 + 1);
    endfunction

    // Width of the flat weight ROM address (class*img_bytes + byte).
    function automatic int unsigned addr_width(input int unsigned img_bytes,
                                               input int unsigned n_classes);
        return $clog2(img_bytes * n_classes);
    endfunction

endpackage

// File: rtl/bnn_inference_sequencer_if.sv
// UART-side byte handshakes of the BNN sequencer: RX with CTS, TX with ready.
interface bnn_inference_sequencer_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       uart_cts;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    // Sequencer side.
    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output uart_cts,
        output tx_valid,
        output tx_data
    );

    // UART side.
    modport slave (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  uart_cts,
        input  tx_valid,
        input  tx_data
    );

endinterface

// File: rtl/bnn_xnor_popcount8.sv
// Combinational XNOR-popcount of two bytes: number of matching bit positions.
module bnn_xnor_popcount8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [3:0] cnt_o
);

    logic [7:0] match;

    // Count bit positions where the operands agree.
    always_comb begin
        match = ~(a_i ^ b_i);
        cnt_o = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + {3'b000, match[i]};
        end
    end

endmodule

// File: rtl/bnn_inference_sequencer.sv
// Receives an image over UART, scores it against every class in the weight
// ROM with XNOR-popcount, and sends back (winning class, score).
module bnn_inference_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_BYTES = DefImgBytes,
    parameter int unsigned N_CLASSES = DefNClasses,
    localparam int unsigned AddrW    = addr_width(IMG_BYTES, N_CLASSES)
) (
    input  logic                        clk,
    input  logic                        rst,
    bnn_inference_sequencer_if.master   uart,
    output logic [AddrW-1:0]            w_addr_o,
    input  logic [7:0]                  w_data_i,
    output logic                        busy_o,
    output logic                        err_overrun_o
);

    localparam int unsigned AccW = acc_width(IMG_BYTES);
    localparam int unsigned NumW = IMG_BYTES * N_CLASSES;
    localparam int unsigned KW   = $clog2(NumW + 1);
    localparam int unsigned BW   = $clog2(IMG_BYTES + 1);
    localparam int unsigned CW   = $clog2(N_CLASSES + 1);

    localparam logic [BW-1:0] LastByte = BW'(IMG_BYTES - 1);
    localparam logic [KW-1:0] LastK    = KW'(NumW);

    state_e                 state_q, state_d;
    logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [CW-1:0]          class_cnt_q, class_cnt_d;
    logic [KW-1:0]          k_q, k_d;
    logic [AccW-1:0]        acc_q, acc_d;
    logic [AccW-1:0]        best_score_q, best_score_d;
    logic [CW-1:0]          best_cls_q, best_cls_d;
    logic [IMG_BYTES*8-1:0] img_q, img_d;
    logic                   err_q, err_d;

    logic [7:0]             img_byte;
    logic [3:0]             pc;
    logic [AccW-1:0]        total;
    logic                   cts;
    logic                   tx_valid;
    logic [7:0]             tx_data;
    logic [AddrW-1:0]       w_addr;

    // byte_cnt tracks the byte whose weight is arriving this cycle during COMP.
    assign img_byte = img_q[int'(byte_cnt_q) * 8 +: 8];

    bnn_xnor_popcount8 u_popcount (
        .a_i   (img_byte),
        .b_i   (w_data_i),
        .cnt_o (pc)
    );

    assign total = acc_q + AccW'(pc);

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        class_cnt_d  = class_cnt_q;
        k_d          = k_q;
        acc_d        = acc_q;
        best_score_d = best_score_q;
        best_cls_d   = best_cls_q;
        img_d        = img_q;
        err_d        = err_q;
        cts          = 1'b0;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        w_addr       = '0;

        unique case (state_q)
            S_RECV: begin
                cts = 1'b1;
                if (uart.rx_valid) begin
                    img_d[int'(byte_cnt_q) * 8 +: 8] = uart.rx_data;
                    if (byte_cnt_q == LastByte) begin
                        byte_cnt_d   = '0;
                        class_cnt_d  = '0;
                        k_d          = '0;
                        acc_d        = '0;
                        best_score_d = '0;
                        best_cls_d   = '0;
                        state_d      = S_COMP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end
            S_COMP: begin
                if (k_q != LastK) begin
                    w_addr = k_q[AddrW-1:0];
                end
                // ROM data lags the address by one cycle, so k=0 has nothing to add.
                if (k_q != '0) begin
                    if (byte_cnt_q == LastByte) begin
                        if (total > best_score_q) begin
                            best_score_d = total;
                            best_cls_d   = class_cnt_q;
                        end
                        acc_d       = '0;
                        byte_cnt_d  = '0;
                        class_cnt_d = class_cnt_q + CW'(1);
                    end else begin
                        acc_d      = total;
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
                if (k_q == LastK) begin
                    k_d     = '0;
                    state_d = S_SEND_CLS;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_SEND_CLS: begin
                tx_valid = 1'b1;
                tx_data  = 8'(best_cls_q);
                if (uart.tx_ready) begin
                    state_d = S_SEND_SCORE;
                end
            end
            S_SEND_SCORE: begin
                tx_valid = 1'b1;
                tx_data  = 8'(best_score_q);
                if (uart.tx_ready) begin
                    state_d = S_RECV;
                end
            end
            default: state_d = S_RECV;
        endcase

        // A byte offered while CTS is low is dropped and flagged.
        if (uart.rx_valid && !cts) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RECV;
            byte_cnt_q   <= '0;
            class_cnt_q  <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            best_score_q <= '0;
            best_cls_q   <= '0;
            img_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            class_cnt_q  <= class_cnt_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            best_score_q <= best_score_d;
            best_cls_q   <= best_cls_d;
            img_q        <= img_d;
            err_q        <= err_d;
        end
    end

    assign uart.uart_cts = cts;
    assign uart.tx_valid = tx_valid;
    assign uart.tx_data  = tx_data;
    assign w_addr_o      = w_addr;
    assign busy_o        = (state_q != S_RECV);
    assign err_overrun_o = err_q;

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// Directed bench for bnn_inference_sequencer with a synchronous weight ROM model.
module tb_bnn_inference_sequencer;

    localparam int unsigned IMG = 8;
    localparam int unsigned NC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] w_addr;
    logic [7:0] w_data;
    logic       busy;
    logic       err;
    logic [7:0] rom [IMG*NC];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bnn_inference_sequencer_if u_if ();

    bnn_inference_sequencer #(
        .IMG_BYTES (IMG),
        .N_CLASSES (NC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart          (u_if),
        .w_addr_o      (w_addr),
        .w_data_i      (w_data),
        .busy_o        (busy),
        .err_overrun_o (err)
    );

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rom(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        for (int b = 0; b < IMG; b++) begin
            rom[0*IMG+b] = c0;
            rom[1*IMG+b] = c1;
            rom[2*IMG+b] = c2;
            rom[3*IMG+b] = c3;
        end
    endtask

    // Called at a negedge; returns at the negedge after the last byte's edge.
    task automatic send_frame(input logic [63:0] img);
        for (int i = 0; i < IMG; i++) begin
            u_if.rx_data  = img[i*8 +: 8];
            u_if.rx_valid = 1'b1;
            @(negedge clk);
        end
        u_if.rx_valid = 1'b0;
    endtask

    // Waits (bounded) for a TX handshake sampled at a negedge.
    task automatic get_byte(output logic [7:0] d, output logic ok);
        d  = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (u_if.tx_valid === 1'b1 && u_if.tx_ready === 1'b1) begin
                d  = u_if.tx_data;
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic get_result(input string tag, input logic [7:0] ecls, input logic [7:0] escore);
        logic [7:0] d;
        logic       ok;
        get_byte(d, ok);
        chk({tag, " cls handshake"}, 32'(ok), 32'd1);
        chk({tag, " cls"}, 32'(d), 32'(ecls));
        get_byte(d, ok);
        chk({tag, " score handshake"}, 32'(ok), 32'd1);
        chk({tag, " score"}, 32'(d), 32'(escore));
        chk({tag, " cts after"}, 32'(u_if.uart_cts), 32'd1);
        chk({tag, " busy after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        u_if.tx_ready = 1'b1;
        set_rom(8'h00, 8'h00, 8'hFF, 8'h00);

        // Power-on reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("por cts", 32'(u_if.uart_cts), 32'd1);
        chk("por busy", 32'(busy), 32'd0);
        chk("por tx_valid", 32'(u_if.tx_valid), 32'd0);
        chk("por tx_data", 32'(u_if.tx_data), 32'd0);
        chk("por w_addr", 32'(w_addr), 32'd0);
        chk("por err", 32'(err), 32'd0);

        // Reset in the middle of COMP aborts the frame.
        send_frame({8{8'hFF}});
        @(negedge clk);
        @(negedge clk);
        chk("midcomp busy", 32'(busy), 32'd1);
        chk("midcomp cts", 32'(u_if.uart_cts), 32'd0);
        chk("midcomp w_addr", 32'(w_addr), 32'd2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("abort cts", 32'(u_if.uart_cts), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort tx_valid", 32'(u_if.tx_valid), 32'd0);
        chk("abort err", 32'(err), 32'd0);

        // Clear winner: class 2 matches all 64 bits; COMP lasts 4*8+1 cycles.
        send_frame({8{8'hFF}});
        n = 0;
        while (busy && !u_if.tx_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("clear comp cycles", 32'(n), 32'd33);
        get_result("clear", 8'h02, 8'h40);

        // Tie: 0xAA vs 0x0F matches 4 bits/byte in every class -> lowest index.
        set_rom(8'h0F, 8'h0F, 8'h0F, 8'h0F);
        send_frame({8{8'hAA}});
        get_result("tie", 8'h00, 8'h20);

        // Overrun: byte offered during COMP is dropped and flagged.
        // Scores for image 0x0F: c0=56, c1=0, c2=0, c3=64.
        set_rom(8'h0E, 8'hF0, 8'hF0, 8'h0F);
        send_frame({8{8'h0F}});
        repeat (3) @(negedge clk);
        u_if.rx_data  = 8'hFF;
        u_if.rx_valid = 1'b1;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        chk("overrun flag", 32'(err), 32'd1);
        get_result("overrun", 8'h03, 8'h40);
        chk("overrun sticky", 32'(err), 32'd1);

        // Backpressure in SEND_CLS. Image 0xF0: c0=8, c1=64, c2=64, c3=0 -> class 1.
        u_if.tx_ready = 1'b0;
        send_frame({8{8'hF0}});
        n = 0;
        while (!u_if.tx_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("bp tx_valid seen", 32'(u_if.tx_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp hold valid", 32'(u_if.tx_valid), 32'd1);
            chk("bp hold data", 32'(u_if.tx_data), 32'd1);
            @(negedge clk);
        end
        u_if.tx_ready = 1'b1;
        get_result("bp", 8'h01, 8'h40);
        n = 0;
        repeat (5) begin
            if (u_if.tx_valid) n++;
            @(negedge clk);
        end
        chk("bp no extra bytes", 32'(n), 32'd0);
        chk("bp err sticky", 32'(err), 32'd1);

        // Back-to-back frames. Image 0x0E: c0=64, c1=8, c2=8, c3=56.
        send_frame({8{8'h0F}});
        get_result("b2b first", 8'h03, 8'h40);
        send_frame({8{8'h0E}});
        get_result("b2b second", 8'h00, 8'h40);

        // Only reset clears the overrun flag.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err cleared by rst", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
